// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver: gathers 7-bit codewords, corrects single
// errors and assembles WIDTH/4 nibbles into a word handed out by valid/ready.
// Ports: clk, rst (async, active-low), clear (sync abort), sin_valid/sin_data/
// sin_ready (serial in), word_out/word_valid/word_ready (word out), corr_flag,
// err_count (only with HAMMING_RX_ERRCNT_EN defined).
module hamming_serial_rx #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             corr_flag
`ifdef HAMMING_RX_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic [NW-1:0]    nib_q, nib_d;
  logic [5:0]       cw_q, cw_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             corr_q, corr_d;

  logic       accept;
  logic [6:0] code;
  logic [3:0] dat;
  logic [2:0] par;
  logic [2:0] syn;
  logic [3:0] fix;

`ifdef HAMMING_RX_ERRCNT_EN
  logic [15:0] errc_q, errc_d;
  assign err_count = errc_q;
`endif

  assign sin_ready  = (state_q == COLLECT);
  assign word_valid = (state_q == HOLD);
  assign word_out   = word_q;
  assign corr_flag  = corr_q;

  // Last bit comes straight from the pin so the nibble lands this edge.
  assign accept = sin_valid && (state_q == COLLECT);
  assign code   = {sin_data, cw_q};
  assign dat    = code[3:0];
  assign par    = code[6:4];
  assign syn[0] = par[0] ^ dat[3] ^ dat[2] ^ dat[0];
  assign syn[1] = par[1] ^ dat[3] ^ dat[1] ^ dat[0];
  assign syn[2] = par[2] ^ dat[2] ^ dat[1] ^ dat[0];

  // Single-weight syndromes are parity-bit errors: data untouched.
  always_comb begin
    fix = 4'b0000;
    case (syn)
      3'b111:  fix = 4'b0001;
      3'b110:  fix = 4'b0010;
      3'b101:  fix = 4'b0100;
      3'b011:  fix = 4'b1000;
      default: fix = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    nib_d   = nib_q;
    cw_d    = cw_q;
    word_d  = word_q;
    corr_d  = corr_q;
`ifdef HAMMING_RX_ERRCNT_EN
    errc_d  = errc_q;
`endif
    if (clear) begin
      state_d = COLLECT;
      bit_d   = '0;
      nib_d   = '0;
      cw_d    = '0;
      word_d  = '0;
      corr_d  = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (bit_q != 3'd6) begin
              cw_d[bit_q] = sin_data;
              bit_d       = bit_q + 3'd1;
            end else begin
              bit_d = '0;
              word_d[4*nib_q +: 4] = dat ^ fix;
              if (syn != 3'b000) begin
                corr_d = 1'b1;
`ifdef HAMMING_RX_ERRCNT_EN
                if (errc_q != 16'hFFFF)
                  errc_d = errc_q + 16'd1;
`endif
              end
              if (nib_q == NW'(NIB - 1)) begin
                nib_d   = '0;
                state_d = HOLD;
              end else begin
                nib_d = nib_q + NW'(1);
              end
            end
          end
        end
        HOLD: begin
          if (word_ready) begin
            state_d = COLLECT;
            bit_d   = '0;
            nib_d   = '0;
            word_d  = '0;
            corr_d  = 1'b0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      bit_q   <= '0;
      nib_q   <= '0;
      cw_q    <= '0;
      word_q  <= '0;
      corr_q  <= 1'b0;
`ifdef HAMMING_RX_ERRCNT_EN
      errc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      nib_q   <= nib_d;
      cw_q    <= cw_d;
      word_q  <= word_d;
      corr_q  <= corr_d;
`ifdef HAMMING_RX_ERRCNT_EN
      errc_q  <= errc_d;
`endif
    end
  end

endmodule

// File: doc/hamming_serial_rx.md
HAMMING_SERIAL_RX -- requirements
Module: hamming_serial_rx

Interface
REQ-001 Parameter WIDTH, default 128, output word width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 clear  input  1  synchronous abort of the word in progress.
REQ-005 sin_valid  input  1  serial bit present on sin_data.
REQ-006 sin_data  input  1  serial code bit.
REQ-007 sin_ready  output  1  block accepts a serial bit this cycle.
REQ-008 word_out  output  WIDTH  assembled, corrected data word.
REQ-009 word_valid  output  1  word_out complete and stable.
REQ-010 word_ready  input  1  downstream accepts word_out.
REQ-011 corr_flag  output  1  at least one codeword of the presented word was corrected.
REQ-012 err_count  output  16  corrected-codeword count; present only under REQ-030.

Function
REQ-013 Serial bit accepted only when sin_valid && sin_ready.
REQ-014 Codeword = 7 bits, sent LSB first as c0..c6 = d0,d1,d2,d3,p1,p2,p3.
REQ-015 Parity definitions: p1=d0^d2^d3; p2=d0^d1^d3; p3=d0^d1^d2.
REQ-016 Syndrome: s0=p1^d3^d2^d0; s1=p2^d3^d1^d0; s2=p3^d2^d1^d0; s={s2,s1,s0}.
REQ-017 Correction map: 111->flip d0; 110->flip d1; 101->flip d2; 011->flip d3; 001/010/100->parity error, data unchanged; 000->no error.
REQ-018 On the 7th accepted bit, the corrected nibble is written to word_out[n*4 +: 4] in the same clock edge; n = nibble counter, nibble 0 first (LSB).
REQ-019 FSM states: COLLECT (sin_ready=1, word_valid=0) and HOLD (sin_ready=0, word_valid=1).
REQ-020 COLLECT->HOLD on the edge that accepts the last bit of nibble WIDTH/4-1; word_valid asserts the next cycle.
REQ-021 HOLD->COLLECT when word_valid && word_ready; bit and nibble counters are zero and word_out clears to 0 on that edge.
REQ-022 word_out and corr_flag hold constant throughout HOLD; no serial bit is accepted in HOLD.
REQ-023 sin_valid low mid-codeword: bit counter holds, no timeout.
REQ-024 corr_flag sets on any nonzero syndrome in the current word and clears on entry to COLLECT.
REQ-025 clear (highest priority, any state): next state COLLECT, counters 0, word_out 0, word_valid 0, corr_flag 0; a serial bit or word handshake in the same cycle is discarded.

Reset
REQ-026 rst low: state COLLECT, counters 0.
REQ-027 rst low: word_out=0, word_valid=0, corr_flag=0, err_count=0, sin_ready=1 (the value of sin_ready after reset release).
REQ-028 Reset mid-codeword or mid-HOLD discards all partial data; no word is presented afterwards.
REQ-029 err_count is cleared by rst only, not by clear.

Configuration
REQ-030 Macro HAMMING_RX_ERRCNT_EN defined: err_count present, +1 per codeword with nonzero syndrome, saturating at 16'hFFFF.
REQ-031 Macro undefined: err_count port and counter logic absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-032 Clean word: bits 1,0,1,0,0,1,0 then 0,1,0,1,1,0,1, sin_valid continuous, word_ready=1 -> word_valid high exactly one cycle, word_out=8'hA5, corr_flag=0.
REQ-033 Data error: first codeword sent as 0,0,1,0,0,1,0 (d0 flipped) -> syndrome 111, word_out=8'hA5, corr_flag=1, err_count=1 when enabled.
REQ-034 Parity error: p2 of the second codeword flipped -> word_out=8'hA5, corr_flag=1.
REQ-035 Backpressure: word_ready=0 for 5 cycles after word_valid -> sin_ready=0, word_out stable at 8'hA5; word_ready=1 -> COLLECT next cycle, word_out=0.
REQ-036 Gaps/abort: sin_valid toggled every other cycle -> same 8'hA5; clear after 9 bits, then a full clean word -> 8'hA5 with no residue.
REQ-037 rst pulse low during HOLD -> word_valid=0, word_out=0, err_count=0 within the same cycle.
